// File: rtl/fpu_lane_sequencer_pkg.sv
// rtl/fpu_lane_sequencer_pkg.sv - shared constants, codes and state type for the FPU lane sequencer
package fpu_pkg;

  // Exception flag bit positions within the 5-bit exeption vector
  localparam int EXC_NX = 0;
  localparam int EXC_NV = 1;
  localparam int EXC_DZ = 2;
  localparam int EXC_UF = 3;
  localparam int EXC_OF = 4;

  // Rounding mode codes
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RUP = 3'd2;
  localparam logic [2:0] RM_RDN = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Operation codes
  localparam logic [1:0] OP_MUL = 2'd2;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // Index width that never collapses to zero bits for a single lane
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_lane_sequencer_if.sv
// rtl/fpu_lane_sequencer_if.sv - request, fpu_top and response signal bundle of the lane sequencer
interface fpu_lane_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
);

  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_mode;
  logic [1:0]             req_operation;
  logic [LANES*WIDTH-1:0] req_srcA;
  logic [LANES*WIDTH-1:0] req_srcB;
  logic [LANES-1:0]       req_exec_mask;

  logic                   fpu_valid;
  logic [2:0]             fpu_mode;
  logic [1:0]             fpu_operation;
  logic [WIDTH-1:0]       fpu_inputA;
  logic [WIDTH-1:0]       fpu_inputB;
  logic [WIDTH-1:0]       fpu_output;
  logic [4:0]             fpu_exeption;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [LANES*WIDTH-1:0] rsp_result;
  logic [4:0]             rsp_exeption;

  // Issue stage and fpu_top side
  modport master (
    output req_valid, req_mode, req_operation, req_srcA, req_srcB, req_exec_mask,
    input  req_ready,
    input  fpu_valid, fpu_mode, fpu_operation, fpu_inputA, fpu_inputB,
    output fpu_output, fpu_exeption,
    input  rsp_valid, rsp_result, rsp_exeption,
    output rsp_ready
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_mode, req_operation, req_srcA, req_srcB, req_exec_mask,
    output req_ready,
    output fpu_valid, fpu_mode, fpu_operation, fpu_inputA, fpu_inputB,
    input  fpu_output, fpu_exeption,
    output rsp_valid, rsp_result, rsp_exeption,
    input  rsp_ready
  );

endinterface

// File: rtl/fpu_lane_sequencer_tag_pipe.sv
// rtl/fpu_lane_sequencer_tag_pipe.sv - DEPTH-stage {valid, lane index} delay line matching the FPU latency
module fpu_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  logic [DEPTH-1:0] valid_q;
  logic [IW-1:0]    idx_q [DEPTH];

  // Shift every cycle so each tag leaves exactly when fpu_top presents that lane's result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/fpu_lane_sequencer.sv
// rtl/fpu_lane_sequencer.sv - issues a masked operand vector lane by lane into fpu_top and gathers the results
module fpu_lane_sequencer
  import fpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LANES   = 4,
  parameter int FPU_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  fpu_lane_sequencer_if.slave bus
);

  localparam int IW = idx_width(LANES);
  localparam int CMAX = (LANES > FPU_LAT + 1) ? LANES : FPU_LAT + 1;
  localparam int CW = idx_width(CMAX) + 1;

  seq_state_t             state;
  logic [CW-1:0]          cnt;
  logic [2:0]             mode_q;
  logic [1:0]             op_q;
  logic [LANES*WIDTH-1:0] src_a_q;
  logic [LANES*WIDTH-1:0] src_b_q;
  logic [LANES-1:0]       mask_q;
  logic [IW-1:0]          issue_idx;

  logic [IW-1:0]          cnt_idx;
  logic [WIDTH-1:0]       lane_a;
  logic [WIDTH-1:0]       lane_b;
  logic                   tag_valid;
  logic [IW-1:0]          tag_idx;
  logic                   collecting;

  assign cnt_idx    = cnt[IW-1:0];
  assign lane_a     = src_a_q[int'(cnt_idx)*WIDTH +: WIDTH];
  assign lane_b     = src_b_q[int'(cnt_idx)*WIDTH +: WIDTH];
  assign collecting = (state == S_ISSUE) || (state == S_DRAIN);

  // The tag pipe is fed from the registered issue outputs so it lines up with fpu_top's own register stages
  fpu_tag_pipe #(
    .DEPTH(FPU_LAT),
    .IW   (IW)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.fpu_valid),
    .in_idx   (issue_idx),
    .out_valid(tag_valid),
    .out_idx  (tag_idx)
  );

  // Sequencer FSM with registered outputs; result capture runs alongside while lanes are in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      mode_q            <= '0;
      op_q              <= '0;
      src_a_q           <= '0;
      src_b_q           <= '0;
      mask_q            <= '0;
      issue_idx         <= '0;
      bus.req_ready     <= 1'b1;
      bus.fpu_valid     <= 1'b0;
      bus.fpu_mode      <= '0;
      bus.fpu_operation <= '0;
      bus.fpu_inputA    <= '0;
      bus.fpu_inputB    <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_result    <= '0;
      bus.rsp_exeption  <= '0;
    end else begin
      if (collecting && tag_valid) begin
        bus.rsp_result[int'(tag_idx)*WIDTH +: WIDTH] <= bus.fpu_output;
        bus.rsp_exeption <= bus.rsp_exeption | bus.fpu_exeption;
      end

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            mode_q           <= bus.req_mode;
            op_q             <= bus.req_operation;
            src_a_q          <= bus.req_srcA;
            src_b_q          <= bus.req_srcB;
            mask_q           <= bus.req_exec_mask;
            bus.rsp_result   <= '0;
            bus.rsp_exeption <= '0;
            bus.req_ready    <= 1'b0;
            cnt              <= '0;
            state            <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Masked lanes still take their slot so the overall latency never depends on the mask
          bus.fpu_valid     <= mask_q[cnt_idx];
          bus.fpu_mode      <= mode_q;
          bus.fpu_operation <= op_q;
          bus.fpu_inputA    <= lane_a;
          bus.fpu_inputB    <= lane_b;
          issue_idx         <= cnt_idx;
          if (cnt == CW'(LANES - 1)) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          // The last lane's tag is consumed on the edge where the count reaches FPU_LAT
          bus.fpu_valid <= 1'b0;
          if (cnt == CW'(FPU_LAT)) begin
            cnt           <= '0;
            bus.rsp_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_lane_sequencer.sv
// tb/tb_fpu_lane_sequencer.sv - directed self-checking bench for fpu_lane_sequencer
module tb_fpu_lane_sequencer;

  localparam int W = 32;
  localparam int L = 4;

  localparam logic [L*W-1:0] A1 = {32'h3fffffff, 32'h00000000, 32'h3f800000, 32'h404ccccd};
  localparam logic [L*W-1:0] B1 = {32'h3fa00000, 32'h3fa00000, 32'hbf800000, 32'h40966666};
  localparam logic [L*W-1:0] R1 = {32'h401fffff, 32'h00000000, 32'hbf800000, 32'h4170a3d7};
  localparam logic [L*W-1:0] A2 = {32'h3fffffff, 32'h00000000, 32'h3f800000, 32'h7f7fffff};
  localparam logic [L*W-1:0] B2 = {32'h3fa00000, 32'h7f800000, 32'hbf800000, 32'h3fffffff};
  localparam logic [L*W-1:0] R2 = {32'h00000000, 32'h7fc00000, 32'h00000000, 32'h7f800000};
  localparam logic [L*W-1:0] M2 = {32'hffffffff, 32'h7fffffff, 32'hffffffff, 32'hffffffff};
  localparam logic [L*W-1:0] A3 = {4{32'h3f80eeff}};
  localparam logic [L*W-1:0] B3 = {4{32'h3f800010}};
  localparam logic [L*W-1:0] R3_RUP = {4{32'h3f80ef10}};
  localparam logic [L*W-1:0] R3_RTZ = {4{32'h3f80ef0f}};

  logic clk;
  logic rst_n;
  logic sel;

  logic           req_valid;
  logic [2:0]     req_mode;
  logic [1:0]     req_op;
  logic [L*W-1:0] req_a;
  logic [L*W-1:0] req_b;
  logic [L-1:0]   req_mask;
  logic           rsp_ready;

  int tests;
  int failed;
  int lat;
  logic [7:0] vpat;
  logic seen;

  fpu_lane_sequencer_if #(.WIDTH(W), .LANES(L)) bus1 ();
  fpu_lane_sequencer_if #(.WIDTH(W), .LANES(L)) bus3 ();

  assign bus1.req_valid     = req_valid & ~sel;
  assign bus1.req_mode      = req_mode;
  assign bus1.req_operation = req_op;
  assign bus1.req_srcA      = req_a;
  assign bus1.req_srcB      = req_b;
  assign bus1.req_exec_mask = req_mask;
  assign bus1.rsp_ready     = rsp_ready;

  assign bus3.req_valid     = req_valid & sel;
  assign bus3.req_mode      = req_mode;
  assign bus3.req_operation = req_op;
  assign bus3.req_srcA      = req_a;
  assign bus3.req_srcB      = req_b;
  assign bus3.req_exec_mask = req_mask;
  assign bus3.rsp_ready     = rsp_ready;

  fpu_lane_sequencer #(.WIDTH(W), .LANES(L), .FPU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fpu_lane_sequencer #(.WIDTH(W), .LANES(L), .FPU_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fpu_top stand-in: table of known products, fixed latency, garbage when not valid
  function automatic logic [36:0] fpu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    logic [63:0] k;
    k = {a, b};
    case (k)
      64'h404ccccd_40966666: return {5'h01, 32'h4170a3d7};
      64'h3f800000_bf800000: return {5'h00, 32'hbf800000};
      64'h00000000_3fa00000: return {5'h00, 32'h00000000};
      64'h3fffffff_3fa00000: return {5'h01, 32'h401fffff};
      64'h7f7fffff_3fffffff: return {5'h11, 32'h7f800000};
      64'h00000000_7f800000: return {5'h02, 32'h7fc00000};
      64'h3f80eeff_3f800010: return (m == 3'd1) ? {5'h01, 32'h3f80ef0f} : {5'h01, 32'h3f80ef10};
      default:               return {5'h00, 32'h00000000};
    endcase
  endfunction

  logic [37:0] p1;
  logic [37:0] p3 [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p1 <= '0;
    else p1 <= {bus1.fpu_valid, fpu_ref(bus1.fpu_inputA, bus1.fpu_inputB, bus1.fpu_mode)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p3[0] <= '0;
      p3[1] <= '0;
      p3[2] <= '0;
    end else begin
      p3[0] <= {bus3.fpu_valid, fpu_ref(bus3.fpu_inputA, bus3.fpu_inputB, bus3.fpu_mode)};
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  assign bus1.fpu_output   = p1[37] ? p1[31:0] : 32'hdeadbeef;
  assign bus1.fpu_exeption = p1[37] ? p1[36:32] : 5'h1f;
  assign bus3.fpu_output   = p3[2][37] ? p3[2][31:0] : 32'hdeadbeef;
  assign bus3.fpu_exeption = p3[2][37] ? p3[2][36:32] : 5'h1f;

  logic           o_req_ready, o_fpu_valid, o_rsp_valid;
  logic [2:0]     o_fpu_mode;
  logic [31:0]    o_fpu_a;
  logic [L*W-1:0] o_rsp_result;
  logic [4:0]     o_rsp_exc;

  assign o_req_ready  = sel ? bus3.req_ready    : bus1.req_ready;
  assign o_fpu_valid  = sel ? bus3.fpu_valid    : bus1.fpu_valid;
  assign o_fpu_mode   = sel ? bus3.fpu_mode     : bus1.fpu_mode;
  assign o_fpu_a      = sel ? bus3.fpu_inputA   : bus1.fpu_inputA;
  assign o_rsp_valid  = sel ? bus3.rsp_valid    : bus1.rsp_valid;
  assign o_rsp_result = sel ? bus3.rsp_result   : bus1.rsp_result;
  assign o_rsp_exc    = sel ? bus3.rsp_exeption : bus1.rsp_exeption;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] m, input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic [L-1:0] mask);
    req_mode  = m;
    req_op    = 2'd2;
    req_a     = a;
    req_b     = b;
    req_mask  = mask;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lt, output logic [7:0] vp);
    lt = 0;
    vp = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c <= 8) vp[c-1] = o_fpu_valid;
      if (o_rsp_valid) begin
        lt = c;
        break;
      end
    end
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_rel_rsp_valid"}, o_rsp_valid, 0);
    chk({tag, "_rel_req_ready"}, o_req_ready, 1);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_mode = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_mask = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_fpu_valid", o_fpu_valid, 0);
    chk("rst_fpu_mode", o_fpu_mode, 0);
    chk("rst_fpu_a", o_fpu_a, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_result", o_rsp_result, 0);
    chk("rst_rsp_exc", o_rsp_exc, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: full mask, RNE
    send(3'd0, A1, B1, 4'b1111);
    chk("s1_req_ready_busy", o_req_ready, 0);
    wait_rsp(lat, vpat);
    chk("s1_latency", lat, 6);
    chk("s1_result", o_rsp_result, R1);
    chk("s1_exc", o_rsp_exc, 5'h01);
    chk("s1_valid_pattern", vpat, 8'h0f);
    release_rsp("s1");

    // Scenario 2: lanes 0 and 2 only, overflow and NaN
    send(3'd0, A2, B2, 4'b0101);
    wait_rsp(lat, vpat);
    chk("s2_latency", lat, 6);
    chk("s2_result", o_rsp_result & M2, R2 & M2);
    chk("s2_exc", o_rsp_exc, 5'h13);
    chk("s2_valid_pattern", vpat, 8'h05);
    release_rsp("s2");

    // Scenario 3: rounding mode follows the request
    send(3'd2, A3, B3, 4'b1111);
    wait_rsp(lat, vpat);
    chk("s3_rup_result", o_rsp_result, R3_RUP);
    chk("s3_rup_exc", o_rsp_exc, 5'h01);
    release_rsp("s3a");
    send(3'd1, A3, B3, 4'b1111);
    wait_rsp(lat, vpat);
    chk("s3_rtz_result", o_rsp_result, R3_RTZ);
    chk("s3_rtz_exc", o_rsp_exc, 5'h01);
    release_rsp("s3b");

    // Scenario 4: response backpressure with a request already waiting
    send(3'd0, A1, B1, 4'b1111);
    wait_rsp(lat, vpat);
    chk("s4_latency", lat, 6);
    req_mode  = 3'd2;
    req_a     = A3;
    req_b     = B3;
    req_mask  = 4'b1111;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("s4_hold_rsp_valid", o_rsp_valid, 1);
      chk("s4_hold_result", o_rsp_result, R1);
      chk("s4_hold_req_ready", o_req_ready, 0);
      chk("s4_hold_fpu_valid", o_fpu_valid, 0);
    end
    release_rsp("s4");
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("s4_next_accepted", o_req_ready, 0);
    wait_rsp(lat, vpat);
    chk("s4_next_latency", lat, 6);
    chk("s4_next_result", o_rsp_result, R3_RUP);
    release_rsp("s4n");

    // Scenario 5: reset while lane 2 is being issued
    send(3'd0, A1, B1, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    chk("s5_lane2_issuing", o_fpu_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_req_ready", o_req_ready, 1);
    chk("s5_rst_fpu_valid", o_fpu_valid, 0);
    chk("s5_rst_fpu_a", o_fpu_a, 0);
    chk("s5_rst_rsp_valid", o_rsp_valid, 0);
    chk("s5_rst_result", o_rsp_result, 0);
    chk("s5_rst_exc", o_rsp_exc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (o_rsp_valid) seen = 1'b1;
    end
    chk("s5_no_partial_rsp", seen, 0);
    send(3'd0, A1, B1, 4'b1111);
    wait_rsp(lat, vpat);
    chk("s5_after_latency", lat, 6);
    chk("s5_after_result", o_rsp_result, R1);
    chk("s5_after_exc", o_rsp_exc, 5'h01);
    release_rsp("s5");

    // Scenario 6: empty mask, then FPU_LAT=3 instance
    send(3'd0, A1, B1, 4'b0000);
    wait_rsp(lat, vpat);
    chk("s6_zero_latency", lat, 6);
    chk("s6_zero_result", o_rsp_result, 0);
    chk("s6_zero_exc", o_rsp_exc, 0);
    chk("s6_zero_valid_pattern", vpat, 8'h00);
    release_rsp("s6a");

    sel = 1'b1;
    #1;
    chk("s6_lat3_idle_ready", o_req_ready, 1);
    send(3'd0, A1, B1, 4'b1111);
    wait_rsp(lat, vpat);
    chk("s6_lat3_latency", lat, 8);
    chk("s6_lat3_result", o_rsp_result, R1);
    chk("s6_lat3_exc", o_rsp_exc, 5'h01);
    chk("s6_lat3_valid_pattern", vpat, 8'h0f);
    release_rsp("s6b");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
